seq_bin2bcd: RTL and testbench

Sequential shift-add-3 (double-dabble) converter that turns the 8-bit product of the 4x4 sequential multiplier into three BCD digits for the seven-segment display path. It sits directly downstream of the multiplier. Its `start` input is driven by the multiplier's ready level, and its `bin` input by the product bus. It converts one bit per clock and reports completion with a `done` pulse and a held `valid` level.

---
 rtl/seq_bin2bcd.sv | 90 +++++++++
 tb/tb_seq_bin2bcd.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: sequential double-dabble converter, one input bit per clock.
// A rising edge on start (sampled in IDLE) launches a conversion; done pulses as bcd updates.
module seq_bin2bcd #(
    parameter int IN_W = 8,
    parameter int ND   = 3
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic [IN_W-1:0]   bin,
    input  logic              start,
    output logic [4*ND-1:0]   bcd,
    output logic              busy,
    output logic              done,
    output logic              valid
);
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [IN_W-1:0]   shift_q, shift_d;
    logic [4*ND-1:0]   scr_q, scr_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*ND-1:0]   bcd_q, bcd_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              accept;

    assign accept = start & ~start_q & (state_q == IDLE);

    // add-3 correction applied to every digit in parallel before the shift
    for (genvar g = 0; g < ND; g++) begin : g_adj
        assign adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3 : scr_q[4*g +: 4];
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        if (accept) begin
            state_d = CONV;
            shift_d = bin;
            scr_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (state_q == CONV) begin
            {scr_d, shift_d} = {adj[4*ND-2:0], shift_q, 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                bcd_d   = scr_d;
                done_d  = 1'b1;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign bcd   = bcd_q;
    assign busy  = (state_q == CONV);
    assign done  = done_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: directed and randomized checks of seq_bin2bcd against a decimal reference.
module tb_seq_bin2bcd;
    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic [7:0]  bin = '0;
    logic        start = 1'b0;
    logic [11:0] bcd;
    logic        busy, done, valid;
    int          checks = 0;
    int          failures = 0;

    seq_bin2bcd #(.IN_W(8), .ND(3)) dut (
        .clk(clk), .rst_a(rst_a), .bin(bin), .start(start),
        .bcd(bcd), .busy(busy), .done(done), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // full conversion from a low start: accept edge, 7 silent iterations, done on the 8th
    task automatic conv(input int v, input string tag);
        logic early;
        bin = 8'(v);
        start = 1'b1;
        tick();
        chk({tag, " busy_after_accept"}, busy, 1);
        chk({tag, " valid_cleared"}, valid, 0);
        bin = ~bin;
        early = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            early |= done | valid | ~busy;
        end
        chk({tag, " quiet_during_conv"}, early, 0);
        tick();
        chk({tag, " done"}, done, 1);
        chk({tag, " bcd"}, bcd, ref_bcd(v));
        chk({tag, " valid"}, valid, 1);
        chk({tag, " busy_end"}, busy, 0);
        start = 1'b0;
        tick();
        chk({tag, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int n;
        int v;
        tick();
        tick();
        chk("reset bcd", bcd, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset valid", valid, 0);
        rst_a = 1'b1;
        tick();

        conv(225, "p225");
        conv(0, "p0");
        conv(255, "p255");
        conv(99, "p99");

        bin = 8'd42;
        start = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n += int'(done);
        end
        chk("held one_done", n, 1);
        chk("held bcd", bcd, 12'h042);
        chk("held valid", valid, 1);
        start = 1'b0;
        tick();

        bin = 8'd12;
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        bin = 8'd77;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n += int'(done);
        end
        chk("busy_rise done", n, 1);
        chk("busy_rise bcd", bcd, 12'h012);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n += int'(done);
        end
        chk("busy_rise no_second_done", n, 0);
        chk("busy_rise still_idle", busy, 0);
        start = 1'b0;
        tick();

        bin = 8'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        tick();
        chk("done_rise first_done", done, 1);
        chk("done_rise first_bcd", bcd, 12'h012);
        start = 1'b1;
        bin = 8'd77;
        tick();
        chk("done_rise accepted", busy, 1);
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        tick();
        chk("done_rise second_done", done, 1);
        chk("done_rise second_bcd", bcd, 12'h077);
        tick();

        bin = 8'd200;
        start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        rst_a = 1'b0;
        #1;
        chk("abort bcd", bcd, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort valid", valid, 0);
        tick();
        bin = 8'd163;
        rst_a = 1'b1;
        tick();
        chk("restart busy", busy, 1);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n += int'(done);
        end
        tick();
        chk("restart early_done", n, 0);
        chk("restart done", done, 1);
        chk("restart bcd", bcd, 12'h163);
        tick();

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 255));
            conv(v, $sformatf("rand%0d", v));
        end

        for (int i = 0; i <= 225; i++) conv(i, $sformatf("sweep%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
